ram_ctrl: RTL and testbench

Controller that sequences and shares one dual-port character RAM (1-cycle registered read, synchronous write) between the video scanout reader and the host. Arbitrates the single read port between the two readers with a starvation guard and returns tagged read data. Passes host writes through to the write port. Runs a clear sweep that fills the whole RAM with a fill value. Sits between the text-mode video pipeline/host interface and the RAM instance.

---
 rtl/ram_ctrl_pkg.sv | 11 +
 rtl/ram_rd_arb.sv | 68 ++++++
 rtl/ram_ctrl.sv | 105 ++++++++++
 tb/tb_ram_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types for the character RAM controller: sweep FSM states and read-return tags.
package ram_ctrl_pkg;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

   typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_HOST} tag_e;

   // Starvation counter width; covers STARVE values 1..15.
   localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/ram_rd_arb.sv
// Read-port arbiter: video has priority unless the host has waited STARVE cycles.
// Registers a tag so the returning RAM data can be steered to the right reader.
module ram_rd_arb
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned STARVE = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              v_req,
   input  logic [ADDR_W-1:0] v_addr,
   input  logic              h_req,
   input  logic [ADDR_W-1:0] h_addr,
   output logic              v_gnt,
   output logic              h_gnt,
   output logic [ADDR_W-1:0] raddr,
   output logic              v_valid,
   output logic              h_valid
);

   localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE);

   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   tag_e                tag_q, tag_d;
   logic                host_win;

   assign host_win = h_req && (starve_cnt_q == StarveMax);

   // Grants are forced low during reset so the RAM sees no stray reads.
   always_comb begin
      v_gnt = resetn && v_req && !host_win;
      h_gnt = resetn && h_req && (!v_req || host_win);
      raddr = h_gnt ? h_addr : v_addr;
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!h_req || h_gnt) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != StarveMax) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_comb begin
      tag_d = TAG_NONE;
      if (v_gnt) begin
         tag_d = TAG_VID;
      end else if (h_gnt) begin
         tag_d = TAG_HOST;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt_q <= '0;
         tag_q        <= TAG_NONE;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         tag_q        <= tag_d;
      end
   end

   assign v_valid = (tag_q == TAG_VID);
   assign h_valid = (tag_q == TAG_HOST);

endmodule

// File: rtl/ram_ctrl.sv
// Shares one dual-port character RAM between video scanout and host, and runs a
// full-RAM clear sweep that preempts host writes while reads keep arbitrating.
module ram_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned       ADDR_W = 11,
   parameter int unsigned       DATA_W = 8,
   parameter logic [DATA_W-1:0] FILL   = 'h20,
   parameter int unsigned       STARVE = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              v_req,
   input  logic [ADDR_W-1:0] v_addr,
   output logic              v_gnt,
   output logic              v_valid,
   output logic [DATA_W-1:0] v_data,
   input  logic              h_req,
   input  logic [ADDR_W-1:0] h_addr,
   output logic              h_gnt,
   output logic              h_valid,
   output logic [DATA_W-1:0] h_data,
   input  logic              h_wr_req,
   input  logic [ADDR_W-1:0] h_waddr,
   input  logic [DATA_W-1:0] h_wdata,
   output logic              h_wr_ack,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [DATA_W-1:0] ram_din
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   ram_rd_arb #(
      .ADDR_W (ADDR_W),
      .STARVE (STARVE)
   ) u_rd_arb (
      .clk     (clk),
      .resetn  (resetn),
      .v_req   (v_req),
      .v_addr  (v_addr),
      .h_req   (h_req),
      .h_addr  (h_addr),
      .v_gnt   (v_gnt),
      .h_gnt   (h_gnt),
      .raddr   (ram_raddr),
      .v_valid (v_valid),
      .h_valid (h_valid)
   );

   // Registered RAM output is shared; the tagged valid says who owns it.
   assign v_data = ram_dout;
   assign h_data = ram_dout;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The sweep owns the write port; host writes stay pending until it finishes.
   always_comb begin
      clr_busy  = (state_q == ST_CLEAR);
      ram_we    = resetn && h_wr_req;
      h_wr_ack  = resetn && h_wr_req;
      ram_waddr = h_waddr;
      ram_din   = h_wdata;
      if (state_q == ST_CLEAR) begin
         ram_we    = resetn;
         h_wr_ack  = 1'b0;
         ram_waddr = clr_cnt_q;
         ram_din   = FILL;
      end
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl with a small behavioural RAM and reference memory.
module tb_ram_ctrl;

   localparam int unsigned AW     = 4;
   localparam int unsigned DW     = 8;
   localparam int unsigned DEPTH  = 1 << AW;
   localparam logic [DW-1:0] FILL = 8'h20;
   localparam int unsigned STARVE = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          v_req, h_req, h_wr_req, clr_start;
   logic [AW-1:0] v_addr, h_addr, h_waddr;
   logic [DW-1:0] h_wdata;
   logic          v_gnt, v_valid, h_gnt, h_valid, h_wr_ack, clr_busy, ram_we;
   logic [DW-1:0] v_data, h_data, ram_dout, ram_din;
   logic [AW-1:0] ram_raddr, ram_waddr;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] vq [$];
   logic [DW-1:0] hq [$];
   int            host_wait = 0;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   ram_ctrl #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .FILL   (FILL),
      .STARVE (STARVE)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .v_req     (v_req),
      .v_addr    (v_addr),
      .v_gnt     (v_gnt),
      .v_valid   (v_valid),
      .v_data    (v_data),
      .h_req     (h_req),
      .h_addr    (h_addr),
      .h_gnt     (h_gnt),
      .h_valid   (h_valid),
      .h_data    (h_data),
      .h_wr_req  (h_wr_req),
      .h_waddr   (h_waddr),
      .h_wdata   (h_wdata),
      .h_wr_ack  (h_wr_ack),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .ram_raddr (ram_raddr),
      .ram_dout  (ram_dout),
      .ram_we    (ram_we),
      .ram_waddr (ram_waddr),
      .ram_din   (ram_din)
   );

   // Dual-port RAM: registered read returns old data on a same-cycle write.
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_din;
      ram_dout <= mem[ram_raddr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every returned read is matched against the oldest expected value.
   always @(negedge clk) begin
      if (resetn) begin
         if (v_valid) begin
            if (vq.size() == 0) chk("v_valid_spurious", 32'(v_valid), 32'd0);
            else chk("v_data", 32'(v_data), 32'(vq.pop_front()));
         end
         if (h_valid) begin
            if (hq.size() == 0) chk("h_valid_spurious", 32'(h_valid), 32'd0);
            else chk("h_data", 32'(h_data), 32'(hq.pop_front()));
         end
      end
   end

   // One IDLE-state cycle: host is served if video is idle or it has waited STARVE cycles.
   task automatic cycle(input logic vr, input logic [AW-1:0] va, input logic hr,
                        input logic [AW-1:0] ha, input logic wr, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, output logic exp_h);
      logic exp_v;
      v_req = vr; v_addr = va; h_req = hr; h_addr = ha;
      h_wr_req = wr; h_waddr = wa; h_wdata = wd;
      exp_h = hr && (!vr || host_wait >= int'(STARVE));
      exp_v = vr && !(hr && host_wait >= int'(STARVE));
      if (exp_v) vq.push_back(ref_mem[va]);
      if (exp_h) hq.push_back(ref_mem[ha]);
      if (wr) ref_mem[wa] = wd;
      host_wait = (hr && !exp_h) ? host_wait + 1 : 0;
      @(negedge clk);
      chk("v_gnt", 32'(v_gnt), 32'(exp_v));
      chk("h_gnt", 32'(h_gnt), 32'(exp_h));
      chk("h_wr_ack", 32'(h_wr_ack), 32'(wr));
      @(posedge clk); #1;
   endtask

   task automatic read_all();
      logic eh;
      for (int i = 0; i < int'(DEPTH); i++) cycle(1'b1, AW'(i), 1'b0, '0, 1'b0, '0, '0, eh);
      cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, eh);
   endtask

   initial begin
      logic          eh, hp, found;
      logic [AW-1:0] hpa;
      resetn = 1'b0; clr_start = 1'b0;
      v_req = 1'b1; h_req = 1'b1; h_wr_req = 1'b1;
      v_addr = '0; h_addr = '0; h_waddr = '0; h_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_v_gnt", 32'(v_gnt), 32'd0);
      chk("rst_h_gnt", 32'(h_gnt), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_h_wr_ack", 32'(h_wr_ack), 32'd0);
      chk("rst_v_valid", 32'(v_valid), 32'd0);
      chk("rst_h_valid", 32'(h_valid), 32'd0);
      chk("rst_clr_busy", 32'(clr_busy), 32'd0);
      v_req = 1'b0; h_req = 1'b0; h_wr_req = 1'b0;
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;

      // Clear sweep with a host write held across it.
      clr_start = 1'b1;
      @(negedge clk);
      chk("busy_before_sweep", 32'(clr_busy), 32'd0);
      @(posedge clk); #1;
      clr_start = 1'b0;
      h_wr_req = 1'b1; h_waddr = 4'd3; h_wdata = 8'h41;
      for (int i = 0; i < int'(DEPTH); i++) begin
         @(negedge clk);
         chk("sweep_busy", 32'(clr_busy), 32'd1);
         chk("sweep_we", 32'(ram_we), 32'd1);
         chk("sweep_waddr", 32'(ram_waddr), 32'(i));
         chk("sweep_din", 32'(ram_din), 32'(FILL));
         chk("sweep_ack_stall", 32'(h_wr_ack), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("busy_after_sweep", 32'(clr_busy), 32'd0);
      chk("ack_after_sweep", 32'(h_wr_ack), 32'd1);
      chk("waddr_after_sweep", 32'(ram_waddr), 32'd3);
      @(posedge clk); #1;
      h_wr_req = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = FILL;
      ref_mem[3] = 8'h41;
      read_all();

      // Directed starvation: video granted STARVE cycles, then host once.
      for (int i = 0; i < int'(STARVE) + 2; i++)
         cycle(1'b1, AW'(i), 1'b1, 4'd3, 1'b0, '0, '0, eh);

      // Randomized mixed traffic; host read held until the model grants it.
      hp = 1'b0; hpa = '0;
      for (int n = 0; n < 400; n++) begin
         if (!hp && $urandom_range(0, 2) == 0) begin
            hp = 1'b1; hpa = AW'($urandom);
         end
         cycle($urandom_range(0, 3) != 0, AW'($urandom), hp, hpa,
               $urandom_range(0, 3) == 0, AW'($urandom), DW'($urandom), eh);
         if (eh) hp = 1'b0;
      end

      // Same-cycle read and write of one address returns old data, then new.
      cycle(1'b1, 4'd5, 1'b0, '0, 1'b1, 4'd5, 8'h55, eh);
      cycle(1'b1, 4'd5, 1'b0, '0, 1'b0, '0, '0, eh);

      // Reset in the middle of a sweep leaves the upper locations untouched.
      for (int i = 0; i < int'(DEPTH); i++)
         cycle(1'b0, '0, 1'b0, '0, 1'b1, AW'(i), DW'(8'hA0 + i), eh);
      h_wr_req = 1'b0;
      clr_start = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      clr_start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (clr_busy && ram_waddr == 4'd7) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("sweep_reached_addr7", 32'(found), 32'd1);
      resetn = 1'b0;
      #1;
      chk("abort_busy", 32'(clr_busy), 32'd0);
      chk("abort_we", 32'(ram_we), 32'd0);
      for (int i = 0; i < 7; i++) ref_mem[i] = FILL;
      @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      host_wait = 0;
      read_all();

      chk("vq_drained", 32'(vq.size()), 32'd0);
      chk("hq_drained", 32'(hq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
